inj_sweep_ctrl: RTL and testbench
=================================

Name: inj_sweep_ctrl

Overview:
- Parametrised successor to the key-triggered frame-address generator used for ICAPE2 fault injection.
- Sequences one or many injections over a linear range of frame addresses and hands each address to the ICAP write engine via an en/flag handshake.
- Adds single, sweep and continuous-loop modes; per-injection timeout; settle gap; abort; progress counters.
- Sits between the user trigger (key) and the ICAP register writer.

Parameters:
- ADDR_W, 32, frame address width
- CNT_W, 16, width of frame_count, idx and inj_count
- ADDR_STEP, 1, address increment between successive injections
- SETTLE_CYC, 16, idle cycles between flag and next en (0 = none)
- TIMEOUT_CYC, 65535, max cycles waiting for flag before error

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- key  in  1  asynchronous start level; rising edge starts a run
- abort  in  1  synchronous abort request, level
- mode  in  2  0=single, 1=sweep, 2=loop, 3=reserved (treated as single)
- base_addr  in  ADDR_W  first frame address
- frame_count  in  CNT_W  number of addresses per pass
- flag  in  1  injection-complete pulse from the writer
- en  out  1  one-cycle injection start pulse to the writer
- frameaddr  out  ADDR_W  address for the current injection
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse
- err_timeout  out  1  sticky timeout error
- inj_count  out  CNT_W  completed injections this run, saturating
- pass_count  out  CNT_W  completed passes (loop mode), saturating

Behaviour:
- Reset: clk and rst are fixed as one clock, asynchronous active-high reset. All outputs 0; FSM in IDLE; sync flops 0.
- key path: 2-flop synchroniser plus previous-value flop. Start is synchronised rising edge. If N is the first cycle key is sampled high, en is high in cycle N+3. Start is ignored unless in IDLE.
- Start latches: mode, base_addr, frame_count. Clears inj_count, pass_count, err_timeout, idx.
- Effective count: single mode is 1. Sweep and loop use frame_count. Count 0 means IDLE→DONE directly; no en; done pulses.
- Address: frameaddr = latched_base + idx*ADDR_STEP, modulo 2^ADDR_W (wrap silently).
  - Updated on entry to ISSUE.
  - Held stable until next ISSUE or return to IDLE; keeps last value in IDLE.
- States:
  - IDLE: on start → ISSUE, or DONE if count 0.
  - ISSUE: en=1 for exactly this cycle → WAIT.
  - WAIT: on flag → inj_count++; → SETTLE, or NEXT if SETTLE_CYC=0. After TIMEOUT_CYC cycles without flag → set err_timeout → DONE.
  - SETTLE: count SETTLE_CYC cycles → NEXT.
  - NEXT: if idx+1 < count, idx++ → ISSUE.
    - Else in loop mode: idx=0, pass_count++ → ISSUE.
    - Else pass_count++ → DONE.
  - DONE: done=1 for one cycle → IDLE.
- busy=1 in every state except IDLE.
- flag outside WAIT is ignored. flag in the same cycle as en (ISSUE) is ignored.
- abort=1 in any non-IDLE state other than DONE → DONE next cycle; no further en.
  - abort and flag in the same WAIT cycle: inj_count still increments, abort wins.
  - abort in IDLE has no effect and blocks nothing.
- Simultaneous timeout expiry and flag: flag wins; no error.
- Counters saturate at all-ones.
- rst mid-run: immediate return to IDLE with all outputs 0; any writer transfer in flight is abandoned.
- Loop mode runs until abort or timeout.

Test Plan:
- Reset check: assert rst mid-sweep at idx 3 → en, busy, done, frameaddr, inj_count all 0 asynchronously; next key edge restarts cleanly from idx 0.
- Single mode, base_addr=0x00400100, flag returned 5 cycles after en:
  - en exactly once, 3 cycles after key sampled high.
  - frameaddr=0x00400100; inj_count=1.
  - done one cycle after the flag cycle + SETTLE_CYC+1 path.
  - busy falls with done.
- Sweep mode, base=0xFFFFFFFE, count=4, ADDR_STEP=1 → frameaddr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; 4 en pulses spaced ≥ SETTLE_CYC; inj_count=4; pass_count=1.
- Timeout: sweep count=3, writer never returns flag on the 2nd injection → err_timeout=1 after TIMEOUT_CYC; done pulse; inj_count=1; no third en. err_timeout clears on next start.
- Loop mode, count=2:
  - Run 3 passes; pass_count=3 after 6 flags.
  - Assert abort together with the 7th flag → inj_count=7; done next cycle; no 8th en.
- Edge cases:
  - frame_count=0 in sweep → done with no en.
  - key held high, or re-pulsed while busy → no restart.
  - flag pulsed in IDLE → counters unchanged.

Source files
------------

// File: rtl/inj_sweep_ctrl.sv
// rtl/inj_sweep_ctrl.sv - key-triggered frame-address sequencer for ICAP fault injection
// Issues single, sweep or looping injection runs with settle gap, timeout and abort.
module inj_sweep_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int CNT_W       = 16,
   parameter int ADDR_STEP   = 1,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  frame_count,
   input  logic              flag,
   output logic              en,
   output logic [ADDR_W-1:0] frameaddr,
   output logic              busy,
   output logic              done,
   output logic              err_timeout,
   output logic [CNT_W-1:0]  inj_count,
   output logic [CNT_W-1:0]  pass_count
);
   localparam int TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
   localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] ST_LAST = TMR_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_SETTLE, S_NEXT, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic                key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_prev_q, key_prev_d;
   logic                start_q, start_d;
   logic                loop_q, loop_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, idx_q, idx_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                en_q, en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [ADDR_W-1:0]   frameaddr_q, frameaddr_d;
   logic [CNT_W-1:0]    inj_q, inj_d, pass_q, pass_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      key_s1_d   = key;
      key_s2_d   = key_s1_q;
      key_prev_d = key_s2_q;
      start_d    = key_s2_q & ~key_prev_q;
      state_d    = state_q;
      loop_d     = loop_q;
      base_d     = base_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      tmr_d      = tmr_q;
      err_d      = err_q;
      inj_d      = inj_q;
      pass_d     = pass_q;
      case (state_q)
         S_IDLE: begin
            if (start_q) begin
               loop_d  = (mode == 2'd2);
               base_d  = base_addr;
               cnt_d   = (mode == 2'd1 || mode == 2'd2) ? frame_count : CNT_W'(1);
               idx_d   = '0;
               inj_d   = '0;
               pass_d  = '0;
               err_d   = 1'b0;
               state_d = (cnt_d == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmr_d   = '0;
            state_d = abort ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            // A flag on the final timeout cycle still counts as success.
            if (flag) begin
               inj_d   = sat_inc(inj_q);
               tmr_d   = '0;
               state_d = (SETTLE_CYC == 0) ? S_NEXT : S_SETTLE;
            end else if (tmr_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
            if (abort) state_d = S_DONE;
         end
         S_SETTLE: begin
            if (abort) state_d = S_DONE;
            else if (tmr_q == ST_LAST) state_d = S_NEXT;
            else tmr_d = tmr_q + 1'b1;
         end
         S_NEXT: begin
            if (abort) begin
               state_d = S_DONE;
            end else if (({1'b0, idx_q} + 1'b1) < {1'b0, cnt_q}) begin
               idx_d   = idx_q + 1'b1;
               state_d = S_ISSUE;
            end else begin
               pass_d = sat_inc(pass_q);
               if (loop_q) begin
                  idx_d   = '0;
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      en_d        = (state_d == S_ISSUE);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      frameaddr_d = frameaddr_q;
      if (state_d == S_ISSUE && state_q != S_ISSUE)
         frameaddr_d = base_d + ADDR_W'(idx_d) * ADDR_W'(ADDR_STEP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         key_s1_q    <= 1'b0;
         key_s2_q    <= 1'b0;
         key_prev_q  <= 1'b0;
         start_q     <= 1'b0;
         loop_q      <= 1'b0;
         base_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         tmr_q       <= '0;
         en_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         frameaddr_q <= '0;
         inj_q       <= '0;
         pass_q      <= '0;
      end else begin
         state_q     <= state_d;
         key_s1_q    <= key_s1_d;
         key_s2_q    <= key_s2_d;
         key_prev_q  <= key_prev_d;
         start_q     <= start_d;
         loop_q      <= loop_d;
         base_q      <= base_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         tmr_q       <= tmr_d;
         en_q        <= en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         frameaddr_q <= frameaddr_d;
         inj_q       <= inj_d;
         pass_q      <= pass_d;
      end
   end

   assign en          = en_q;
   assign frameaddr   = frameaddr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_timeout = err_q;
   assign inj_count   = inj_q;
   assign pass_count  = pass_q;
endmodule

// File: tb/tb_inj_sweep_ctrl.sv
// tb/tb_inj_sweep_ctrl.sv - directed table bench for inj_sweep_ctrl
module tb_inj_sweep_ctrl;
   localparam int SETTLE = 4;
   localparam int TOUT   = 20;

   logic        clk, rst, key, abort, flag;
   logic [1:0]  mode;
   logic [31:0] base_addr;
   logic [15:0] frame_count;
   logic        en, busy, done, err_timeout;
   logic [31:0] frameaddr;
   logic [15:0] inj_count, pass_count;

   int checks = 0;
   int errors = 0;

   inj_sweep_ctrl #(
      .ADDR_W(32), .CNT_W(16), .ADDR_STEP(1), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TOUT)
   ) dut (
      .clk(clk), .rst(rst), .key(key), .abort(abort), .mode(mode),
      .base_addr(base_addr), .frame_count(frame_count), .flag(flag),
      .en(en), .frameaddr(frameaddr), .busy(busy), .done(done),
      .err_timeout(err_timeout), .inj_count(inj_count), .pass_count(pass_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] base;
      logic [15:0] cnt;
      int          lat;
      int          drop;
      int          abort_flag;
      bit          repulse;
      int          x_en;
      int          x_inj;
      int          x_pass;
      int          x_err;
      int          x_gap;
      bit          gap_en;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int cyc = 0, n_en = 0, n_flag = 0, cd = -1, extra = 0;
      int last_en = -1, last_flag = -1, done_cyc = -1, min_gap = 1000, eff;
      logic [31:0] exp_addr;
      eff = (v.mode == 2'd1 || v.mode == 2'd2) ? int'(v.cnt) : 1;
      @(negedge clk);
      mode = v.mode; base_addr = v.base; frame_count = v.cnt; key = 1'b1;
      while (done_cyc < 0 && cyc < 600) begin
         @(negedge clk);
         cyc++;
         flag = 1'b0;
         abort = 1'b0;
         if (v.repulse && cyc == 8) key = 1'b0;
         if (v.repulse && cyc == 10) key = 1'b1;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               flag = 1'b1;
               n_flag++;
               last_flag = cyc;
               cd = -1;
               if (n_flag == v.abort_flag) abort = 1'b1;
            end
         end
         if (en) begin
            exp_addr = v.base + 32'((eff == 0) ? 0 : (n_en % eff));
            chk("frameaddr", frameaddr, exp_addr);
            if (n_en == 0) begin
               chk("en_latency", cyc, 4);
               chk("err_cleared_on_start", err_timeout, 0);
            end else if (cyc - last_en < min_gap) begin
               min_gap = cyc - last_en;
            end
            if (n_en != v.drop) cd = v.lat;
            last_en = cyc;
            n_en++;
         end
         if (done) begin
            done_cyc = cyc;
            chk("busy_at_done", busy, 1);
         end
      end
      flag = 1'b0;
      abort = 1'b0;
      chk("done_seen", done_cyc >= 0, 1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("busy_after_done", busy, 0);
            chk("done_one_cycle", done, 0);
         end
         if (en) extra++;
      end
      chk("no_en_after_done", extra, 0);
      key = 1'b0;
      chk("en_count", n_en, v.x_en);
      chk("inj_count", inj_count, v.x_inj);
      chk("pass_count", pass_count, v.x_pass);
      chk("err_timeout", err_timeout, v.x_err);
      if (v.x_gap >= 0) chk("done_gap", done_cyc - (v.gap_en ? last_en : last_flag), v.x_gap);
      if (n_en > 1) chk("en_spacing", min_gap >= SETTLE, 1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int n, cd;
      vec_t rv;
      vecs[0] = '{2'd0, 32'h0040_0100, 16'd9, 5, -1, 0, 1'b0, 1, 1, 1, 0, SETTLE + 2, 1'b0};
      vecs[1] = '{2'd3, 32'h0000_1234, 16'd5, 2, -1, 0, 1'b0, 1, 1, 1, 0, SETTLE + 2, 1'b0};
      vecs[2] = '{2'd1, 32'h0000_2000, 16'd3, 3,  1, 0, 1'b0, 2, 1, 0, 1, TOUT + 1,   1'b1};
      vecs[3] = '{2'd1, 32'hFFFF_FFFE, 16'd4, 3, -1, 0, 1'b0, 4, 4, 1, 0, SETTLE + 2, 1'b0};
      vecs[4] = '{2'd1, 32'h0000_0050, 16'd0, 3, -1, 0, 1'b0, 0, 0, 0, 0, -1,         1'b0};
      vecs[5] = '{2'd1, 32'h0000_0300, 16'd2, 3, -1, 0, 1'b1, 2, 2, 1, 0, SETTLE + 2, 1'b0};
      vecs[6] = '{2'd2, 32'h0000_0700, 16'd2, 3, -1, 7, 1'b0, 7, 7, 3, 0, 1,          1'b0};

      rst = 1'b1; key = 1'b0; abort = 1'b0; flag = 1'b0;
      mode = 2'd0; base_addr = '0; frame_count = '0;
      repeat (2) @(negedge clk);
      chk("reset_ctrl", {en, busy, done, err_timeout}, 0);
      chk("reset_addr", frameaddr, 0);
      chk("reset_counts", {inj_count, pass_count}, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Flag and abort while idle must leave the previous run's results alone.
      flag = 1'b1; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (2) @(negedge clk);
      flag = 1'b0;
      @(negedge clk);
      chk("idle_flag_inj", inj_count, 7);
      chk("idle_flag_pass", pass_count, 3);
      chk("idle_flag_busy", busy, 0);

      // Asynchronous reset in the middle of a sweep at index 3.
      @(negedge clk);
      mode = 2'd1; base_addr = 32'h0000_4000; frame_count = 16'd8; key = 1'b1;
      n = 0; cd = -1;
      for (int c = 0; c < 300 && n < 4; c++) begin
         @(negedge clk);
         flag = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) flag = 1'b1;
         end
         if (en) begin
            n++;
            cd = 2;
         end
      end
      chk("rst_reached_idx3", n, 4);
      @(negedge clk);
      flag = 1'b0;
      chk("rst_pre_addr", frameaddr, 32'h0000_4003);
      #2 rst = 1'b1;
      #1;
      chk("midrun_rst_ctrl", {en, busy, done, err_timeout}, 0);
      chk("midrun_rst_addr", frameaddr, 0);
      chk("midrun_rst_counts", {inj_count, pass_count}, 0);
      key = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rv = '{2'd1, 32'h0000_4000, 16'd2, 2, -1, 0, 1'b0, 2, 2, 1, 0, SETTLE + 2, 1'b0};
      run_vec(rv);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
